atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
Front-end session controller that sits directly upstream of the ATM account core.
- Accepts card insertion, verifies the PIN, tracks failed attempts, and locks out accounts.
- Accepts user commands, forwards them as one held request (select, origin, purpose, amount) to the core, and waits for the core's result.
- Translates the core result into a user-facing status and ejects the card at session end.

Parameters:
- NUM_ACCOUNTS, 15: valid account numbers are 0..NUM_ACCOUNTS-1; 4'hF is always invalid.
- MAX_PIN_TRIES, 3: consecutive wrong PINs that lock the account.
- PIN_BASE, 16'h1000: expected PIN = PIN_BASE + account number, 16-bit add, wraps.
- TIMEOUT_CYCLES, 1000: inactivity limit; used only with ATM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- card_in  in  1  one-cycle pulse: card inserted
- card_acc  in  4  account number on the card, valid with card_in
- pin_valid  in  1  one-cycle pulse: PIN entered
- pin_code  in  16  entered PIN
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_sel  in  2  0 = end session, 1 = balance, 2 = withdraw, 3 = transfer
- cmd_amount  in  10  amount for withdraw/transfer
- cmd_dest  in  4  destination account for transfer
- core_req  out  1  request to core, held until response
- core_select  out  2  select code to core
- core_acc_origin  out  4  session account
- core_acc_purpose  out  4  transfer destination (0 when unused)
- core_amount  out  10  amount (0 when unused)
- core_rsp_valid  in  1  core response strobe
- core_result  in  2  0 = none, 1 = withdraw insufficient, 2 = transfer insufficient, 3 = success
- core_inventory  in  10  balance returned for select 1
- status_valid  out  1  one-cycle status pulse
- status_code  out  3  0 OK, 1 insuff-withdraw, 2 insuff-transfer, 3 bad PIN, 4 locked, 5 bad account, 6 timeout, 7 core error
- balance_out  out  10  last reported balance
- session_active  out  1  high in PIN, MENU, REQ
- card_eject  out  1  one-cycle pulse

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- On reset, every output is 0, the FSM goes to IDLE, the attempt counter is cleared, and the lock mask is cleared. Reset mid-request drops the request with no status and no eject.
- States: IDLE, PIN, MENU, REQ.

IDLE:
- card_in with card_acc >= NUM_ACCOUNTS: status 5 plus eject next cycle; stay in IDLE.
- card_in with the account's lock bit set: status 4 plus eject; stay in IDLE.
- Otherwise: latch the account, clear attempts, go to PIN.

PIN:
- pin_valid with a match: clear attempts, go to MENU; no status pulse.
- pin_valid with a mismatch: attempts+1; status 3 next cycle.
- If attempts reaches MAX_PIN_TRIES: set the lock bit, eject, go to IDLE.

MENU:
- cmd_ready = 1 in this state only.
- Accepted sel 0: status 0 plus eject; go to IDLE.
- Accepted sel 3 with cmd_dest >= NUM_ACCOUNTS or cmd_dest == origin: status 5; stay in MENU.
- Any other accepted command: latch the fields, go to REQ.
- Amount 0 is legal and is forwarded.

REQ:
- core_req = 1, with all core_* fields stable, until core_rsp_valid is sampled high.
- On that cycle: capture the result, deassert core_req next cycle, return to MENU.
- Status pulses 1 cycle after core_rsp_valid.
- Result mapping: 3 maps to 0 (balance_out = core_inventory when select = 1); 1 maps to 1; 2 maps to 2; 0 maps to 7.

General rules:
- Outputs are registered.
- card_in outside IDLE, pin_valid outside PIN, and core_rsp_valid outside REQ are ignored.
- core_req is never reasserted in the cycle it drops.
- Lock bits persist across sessions until reset.

Optional Feature:
- Macro: ATM_TIMEOUT_EN.
- Defined: an inactivity counter runs in PIN and MENU and restarts on entry, on pin_valid, and on accepted commands. When it reaches TIMEOUT_CYCLES-1, the block emits status 6 plus eject, goes to IDLE, and clears attempts. The counter is frozen in REQ.
- Undefined: no counter; sessions never expire.

Decomposition:
- Shared package atm_pkg holds:
  - select code constants
  - core result code constants
  - status code enum
  - session state enum
  - ACC_INVALID = 4'hF
- Sub-module atm_pin_guard holds the attempt counter, the per-account lock mask, and the PIN compare. Interfaces: check/match/lock outputs, and a lock-query port indexed by card_acc.

Test Plan:
- Card 5, PIN 16'h1005, cmd sel 1, core returns result 3 / inventory 100 -> status 0, balance_out = 100, core_req held until rsp.
- Card 2, PINs 16'h0000 ×3 -> status 3 ×3, eject after third; reinsert card 2 -> status 4 plus eject.
- Card 15 -> status 5 plus eject, session_active stays 0.
- Card 3, good PIN, sel 3 dest 3 -> status 5, no core_req; sel 3 dest 4 amount 200, core result 2 -> status 2.
- Card 1, good PIN, sel 2 amount 50, assert rst while core_req is high -> all outputs 0, no status or eject; card 2 then opens a fresh session.
- ATM_TIMEOUT_EN with TIMEOUT_CYCLES = 16: card 0, no PIN for 16 cycles -> status 6 plus eject, FSM in IDLE.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session front-end: command select codes,
// core result codes, user-facing status codes and the session state encoding.
package atm_pkg;

  // Card number that never names a real account.
  localparam logic [3:0] ACC_INVALID = 4'hF;

  // Command / core select codes.
  localparam logic [1:0] SEL_END      = 2'd0;
  localparam logic [1:0] SEL_BALANCE  = 2'd1;
  localparam logic [1:0] SEL_WITHDRAW = 2'd2;
  localparam logic [1:0] SEL_TRANSFER = 2'd3;

  // Result codes returned by the account core.
  localparam logic [1:0] RES_NONE      = 2'd0;
  localparam logic [1:0] RES_INSUFF_WD = 2'd1;
  localparam logic [1:0] RES_INSUFF_TR = 2'd2;
  localparam logic [1:0] RES_SUCCESS   = 2'd3;

  typedef enum logic [2:0] {
    STAT_OK        = 3'd0,
    STAT_INSUFF_WD = 3'd1,
    STAT_INSUFF_TR = 3'd2,
    STAT_BAD_PIN   = 3'd3,
    STAT_LOCKED    = 3'd4,
    STAT_BAD_ACC   = 3'd5,
    STAT_TIMEOUT   = 3'd6,
    STAT_CORE_ERR  = 3'd7
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PIN  = 2'd1,
    S_MENU = 2'd2,
    S_REQ  = 2'd3
  } state_t;

endpackage

// File: rtl/atm_pin_guard.sv
// PIN guard: compares the entered PIN with the account's expected PIN,
// counts consecutive wrong entries and keeps the per-account lock mask.
// The lock mask is queried combinationally with the number on an inserted card.
module atm_pin_guard
  import atm_pkg::*;
#(
  parameter int          MAX_PIN_TRIES = 3,
  parameter logic [15:0] PIN_BASE      = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        check,
  input  logic [3:0]  acc,
  input  logic [15:0] pin_code,
  input  logic [3:0]  query_acc,
  output logic        match,
  output logic        lock,
  output logic        locked
);

  localparam int            AW       = $clog2(MAX_PIN_TRIES + 1);
  localparam logic [AW-1:0] LAST_TRY = AW'(MAX_PIN_TRIES - 1);

  logic [AW-1:0] attempts;
  logic [15:0]   lock_mask;

  // Expected PIN is the base plus the account number, wrapping at 16 bits.
  assign match  = (pin_code == (PIN_BASE + {12'd0, acc}));
  // This wrong entry is the one that exhausts the allowed tries.
  assign lock   = check && !match && (attempts == LAST_TRY);
  assign locked = (query_acc != ACC_INVALID) && lock_mask[query_acc];

  // Attempt counter and lock mask update on each checked PIN entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempts  <= '0;
      // NOTE: the lock mask is state that must start known (all unlocked), so it
      // is reset like any other flop rather than treated as uninitialised storage.
      lock_mask <= '0;
    end else if (clear) begin
      attempts <= '0;
    end else if (check) begin
      if (match) begin
        attempts <= '0;
      end else if (lock) begin
        attempts       <= '0;
        lock_mask[acc] <= 1'b1;
      end else begin
        attempts <= attempts + 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insertion, PIN verification with lockout,
// command acceptance and a held request/response exchange with the account core.
// Optional inactivity timeout is built when ATM_TIMEOUT_EN is defined.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int          NUM_ACCOUNTS   = 15,
  parameter int          MAX_PIN_TRIES  = 3,
  parameter logic [15:0] PIN_BASE       = 16'h1000
`ifdef ATM_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  card_acc,
  input  logic        pin_valid,
  input  logic [15:0] pin_code,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_sel,
  input  logic [9:0]  cmd_amount,
  input  logic [3:0]  cmd_dest,
  output logic        core_req,
  output logic [1:0]  core_select,
  output logic [3:0]  core_acc_origin,
  output logic [3:0]  core_acc_purpose,
  output logic [9:0]  core_amount,
  input  logic        core_rsp_valid,
  input  logic [1:0]  core_result,
  input  logic [9:0]  core_inventory,
  output logic        status_valid,
  output logic [2:0]  status_code,
  output logic [9:0]  balance_out,
  output logic        session_active,
  output logic        card_eject
);

  localparam logic [3:0] ACC_LIMIT = 4'(NUM_ACCOUNTS);

  state_t     state;
  logic [3:0] origin;
  logic       acc_ok, acc_locked, pin_check, pin_match, pin_lock;
  logic       cmd_accept, bad_dest, guard_clear, timeout_fire;

  assign acc_ok      = (card_acc < ACC_LIMIT);
  assign pin_check   = (state == S_PIN) && pin_valid;
  assign cmd_accept  = (state == S_MENU) && cmd_valid && cmd_ready;
  assign bad_dest    = (cmd_dest >= ACC_LIMIT) || (cmd_dest == origin);
  assign guard_clear = ((state == S_IDLE) && card_in && acc_ok && !acc_locked) || timeout_fire;

  atm_pin_guard #(
    .MAX_PIN_TRIES (MAX_PIN_TRIES),
    .PIN_BASE      (PIN_BASE)
  ) u_pin_guard (
    .clk       (clk),
    .rst       (rst),
    .clear     (guard_clear),
    .check     (pin_check),
    .acc       (origin),
    .pin_code  (pin_code),
    .query_acc (card_acc),
    .match     (pin_match),
    .lock      (pin_lock),
    .locked    (acc_locked)
  );

`ifdef ATM_TIMEOUT_EN
  localparam int            TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_timer;

  // Expiry yields to user activity arriving in the same cycle.
  assign timeout_fire = ((state == S_PIN) || (state == S_MENU)) &&
                        (idle_timer == T_LAST) && !pin_check && !cmd_accept;

  // Inactivity timer: cleared outside a session and on activity, frozen in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_timer <= '0;
    end else if ((state == S_IDLE) || pin_check || cmd_accept || timeout_fire ||
                 ((state == S_REQ) && core_rsp_valid)) begin
      idle_timer <= '0;
    end else if (state != S_REQ) begin
      idle_timer <= idle_timer + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Session FSM with all user- and core-facing outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      origin           <= '0;
      cmd_ready        <= 1'b0;
      core_req         <= 1'b0;
      core_select      <= '0;
      core_acc_origin  <= '0;
      core_acc_purpose <= '0;
      core_amount      <= '0;
      status_valid     <= 1'b0;
      status_code      <= '0;
      balance_out      <= '0;
      session_active   <= 1'b0;
      card_eject       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; later assignments in this block
      // override these pulse defaults without creating ordering races.
      status_valid <= 1'b0;
      card_eject   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (card_in) begin
            if (!acc_ok) begin
              status_valid <= 1'b1;
              status_code  <= STAT_BAD_ACC;
              card_eject   <= 1'b1;
            end else if (acc_locked) begin
              status_valid <= 1'b1;
              status_code  <= STAT_LOCKED;
              card_eject   <= 1'b1;
            end else begin
              origin         <= card_acc;
              session_active <= 1'b1;
              state          <= S_PIN;
            end
          end
        end
        S_PIN: begin
          if (pin_valid) begin
            if (pin_match) begin
              cmd_ready <= 1'b1;
              state     <= S_MENU;
            end else begin
              status_valid <= 1'b1;
              status_code  <= STAT_BAD_PIN;
              if (pin_lock) begin
                card_eject     <= 1'b1;
                session_active <= 1'b0;
                state          <= S_IDLE;
              end
            end
          end else if (timeout_fire) begin
            status_valid   <= 1'b1;
            status_code    <= STAT_TIMEOUT;
            card_eject     <= 1'b1;
            session_active <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_MENU: begin
          if (cmd_accept) begin
            if (cmd_sel == SEL_END) begin
              status_valid   <= 1'b1;
              status_code    <= STAT_OK;
              card_eject     <= 1'b1;
              cmd_ready      <= 1'b0;
              session_active <= 1'b0;
              state          <= S_IDLE;
            end else if ((cmd_sel == SEL_TRANSFER) && bad_dest) begin
              status_valid <= 1'b1;
              status_code  <= STAT_BAD_ACC;
            end else begin
              core_req         <= 1'b1;
              core_select      <= cmd_sel;
              core_acc_origin  <= origin;
              core_acc_purpose <= (cmd_sel == SEL_TRANSFER) ? cmd_dest : 4'd0;
              core_amount      <= ((cmd_sel == SEL_WITHDRAW) || (cmd_sel == SEL_TRANSFER)) ?
                                  cmd_amount : 10'd0;
              cmd_ready        <= 1'b0;
              state            <= S_REQ;
            end
          end else if (timeout_fire) begin
            status_valid   <= 1'b1;
            status_code    <= STAT_TIMEOUT;
            card_eject     <= 1'b1;
            cmd_ready      <= 1'b0;
            session_active <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_REQ: begin
          if (core_rsp_valid) begin
            core_req     <= 1'b0;
            cmd_ready    <= 1'b1;
            status_valid <= 1'b1;
            state        <= S_MENU;
            case (core_result)
              RES_SUCCESS: begin
                status_code <= STAT_OK;
                if (core_select == SEL_BALANCE) balance_out <= core_inventory;
              end
              RES_INSUFF_WD: status_code <= STAT_INSUFF_WD;
              RES_INSUFF_TR: status_code <= STAT_INSUFF_TR;
              RES_NONE:      status_code <= STAT_CORE_ERR;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: stimulus tasks consult a session-level
// reference model and queue expected statuses and core requests; a monitor and
// a core responder pop and compare whenever the DUT presents them.
module tb_atm_session_ctrl;

  localparam int          NUM_ACC  = 15;
  localparam logic [15:0] PIN_BASE = 16'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in, pin_valid, cmd_valid, cmd_ready;
  logic [3:0]  card_acc, cmd_dest;
  logic [15:0] pin_code;
  logic [1:0]  cmd_sel, core_select, core_result;
  logic [9:0]  cmd_amount, core_amount, core_inventory, balance_out;
  logic        core_req, core_rsp_valid, status_valid, session_active, card_eject;
  logic [3:0]  core_acc_origin, core_acc_purpose;
  logic [2:0]  status_code;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .NUM_ACCOUNTS   (NUM_ACC),
    .MAX_PIN_TRIES  (3),
    .PIN_BASE       (PIN_BASE)
`ifdef ATM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .card_in          (card_in),
    .card_acc         (card_acc),
    .pin_valid        (pin_valid),
    .pin_code         (pin_code),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_sel          (cmd_sel),
    .cmd_amount       (cmd_amount),
    .cmd_dest         (cmd_dest),
    .core_req         (core_req),
    .core_select      (core_select),
    .core_acc_origin  (core_acc_origin),
    .core_acc_purpose (core_acc_purpose),
    .core_amount      (core_amount),
    .core_rsp_valid   (core_rsp_valid),
    .core_result      (core_result),
    .core_inventory   (core_inventory),
    .status_valid     (status_valid),
    .status_code      (status_code),
    .balance_out      (balance_out),
    .session_active   (session_active),
    .card_eject       (card_eject)
  );

  typedef struct {
    logic [2:0] code;
    logic       eject;
    logic [9:0] bal;
  } stat_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] origin;
    logic [3:0] purpose;
    logic [9:0] amount;
    logic [1:0] result;
    logic [9:0] inv;
    int         delay;
    bit         drop;
  } req_t;

  stat_t stat_q[$];
  req_t  req_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    resp_busy = 1'b0;

  // Session-level reference model.
  bit [15:0]  m_lock  = '0;
  int         m_tries = 0;
  logic [3:0] m_acc   = '0;
  int         m_phase = 0;   // 0 no session, 1 awaiting PIN, 2 at menu
  logic [9:0] m_bal   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] map_result(input logic [1:0] r);
    case (r)
      2'd3:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd7;
    endcase
  endfunction

  task automatic push_stat(input logic [2:0] code, input logic ej);
    stat_t s;
    s.code = code;
    s.eject = ej;
    s.bal = m_bal;
    stat_q.push_back(s);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {cmd_ready, core_req, core_select, core_acc_origin, core_acc_purpose,
                            core_amount, status_valid, status_code, session_active, card_eject}, 0);
    check({name, "_balance"}, balance_out, 0);
  endtask

  // Monitor: every status pulse must match the oldest queued expectation.
  initial begin : monitor
    stat_t e;
    forever begin
      @(negedge clk);
      if (!rst && (status_valid || card_eject)) begin
        if (stat_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_status: code=%0d eject=%0b with nothing expected at %0t",
                   status_code, card_eject, $time);
        end else begin
          e = stat_q.pop_front();
          check("status_valid", status_valid, 1);
          check("status_code", status_code, e.code);
          check("card_eject", card_eject, e.eject);
          check("balance_out", balance_out, e.bal);
        end
      end
    end
  end

  // Core responder: checks each request against the queue, holds, then answers.
  initial begin : responder
    req_t r;
    core_rsp_valid = 1'b0;
    core_result    = '0;
    core_inventory = '0;
    forever begin
      @(negedge clk);
      if (!rst && core_req) begin
        resp_busy = 1'b1;
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_core_req: select=%0d origin=%0d at %0t",
                   core_select, core_acc_origin, $time);
          r = '{sel: core_select, origin: core_acc_origin, purpose: core_acc_purpose,
                amount: core_amount, result: 2'd0, inv: 10'd0, delay: 0, drop: 1'b0};
        end else begin
          r = req_q.pop_front();
        end
        check("core_select", core_select, r.sel);
        check("core_acc_origin", core_acc_origin, r.origin);
        check("core_acc_purpose", core_acc_purpose, r.purpose);
        check("core_amount", core_amount, r.amount);
        if (r.drop) begin
          for (int i = 0; i < 200 && core_req; i++) @(negedge clk);
        end else begin
          for (int i = 0; i < r.delay; i++) begin
            @(negedge clk);
            check("core_req_held", core_req, 1);
            check("core_fields_stable", {core_select, core_acc_origin, core_acc_purpose, core_amount},
                  {r.sel, r.origin, r.purpose, r.amount});
          end
          core_rsp_valid = 1'b1;
          core_result    = r.result;
          core_inventory = r.inv;
          @(negedge clk);
          core_rsp_valid = 1'b0;
          core_result    = 2'($urandom);
          core_inventory = 10'($urandom);
          check("core_req_dropped", core_req, 0);
        end
        resp_busy = 1'b0;
      end else if (!rst && ($urandom_range(0, 7) == 0)) begin
        // Stray response while no request is outstanding must be ignored.
        core_rsp_valid = 1'b1;
        core_result    = 2'($urandom);
        core_inventory = 10'($urandom);
        @(negedge clk);
        core_rsp_valid = 1'b0;
      end
    end
  end

  task automatic do_card(input logic [3:0] acc);
    if (m_phase == 0) begin
      if (acc >= NUM_ACC) push_stat(3'd5, 1'b1);
      else if (m_lock[acc]) push_stat(3'd4, 1'b1);
      else begin
        m_phase = 1;
        m_acc   = acc;
        m_tries = 0;
      end
    end
    @(negedge clk);
    card_in  = 1'b1;
    card_acc = acc;
    @(negedge clk);
    card_in  = 1'b0;
    card_acc = 4'($urandom);
    @(negedge clk);
    check("session_active_card", session_active, (m_phase != 0));
  endtask

  task automatic do_pin(input logic [15:0] code);
    logic [15:0] good;
    good = PIN_BASE + 16'(m_acc);
    if (m_phase == 1) begin
      if (code == good) m_phase = 2;
      else begin
        m_tries++;
        if (m_tries >= 3) begin
          m_lock[m_acc] = 1'b1;
          m_phase = 0;
          push_stat(3'd3, 1'b1);
        end else begin
          push_stat(3'd3, 1'b0);
        end
      end
    end
    @(negedge clk);
    pin_valid = 1'b1;
    pin_code  = code;
    @(negedge clk);
    pin_valid = 1'b0;
    pin_code  = 16'($urandom);
    @(negedge clk);
    check("session_active_pin", session_active, (m_phase != 0));
    check("cmd_ready_pin", cmd_ready, (m_phase == 2));
  endtask

  task automatic do_cmd(input logic [1:0] sel, input logic [9:0] amt, input logic [3:0] dest,
                        input logic [1:0] result, input logic [9:0] inv, input int delay,
                        input bit drop);
    req_t r;
    bit   fwd;
    fwd = 1'b0;
    if (sel == 2'd0) begin
      push_stat(3'd0, 1'b1);
      m_phase = 0;
    end else if (sel == 2'd3 && (dest >= NUM_ACC || dest == m_acc)) begin
      push_stat(3'd5, 1'b0);
    end else begin
      fwd       = 1'b1;
      r.sel     = sel;
      r.origin  = m_acc;
      r.purpose = (sel == 2'd3) ? dest : 4'd0;
      r.amount  = (sel == 2'd1) ? 10'd0 : amt;
      r.result  = result;
      r.inv     = inv;
      r.delay   = delay;
      r.drop    = drop;
      req_q.push_back(r);
      if (!drop) begin
        if (result == 2'd3 && sel == 2'd1) m_bal = inv;
        push_stat(map_result(result), 1'b0);
      end
    end
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_sel    = sel;
    cmd_amount = amt;
    cmd_dest   = dest;
    check("cmd_ready_menu", cmd_ready, 1);
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_sel    = 2'($urandom);
    cmd_amount = 10'($urandom);
    cmd_dest   = 4'($urandom);
    if (fwd && !drop) begin
      int n;
      n = 0;
      while ((req_q.size() != 0 || resp_busy || core_req) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        checks++;
        failures++;
        $display("FAIL core_exchange_timeout: core_req=%0b still pending after %0d cycles", core_req, n);
      end
    end
    if (!drop) begin
      @(negedge clk);
      check("session_active_cmd", session_active, (m_phase != 0));
    end
  endtask

  task automatic random_session();
    logic [3:0]  acc;
    logic [15:0] good;
    int          ncmd;
    acc = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, NUM_ACC - 1));
    do_card(acc);
    if (m_phase == 1) begin
      good = PIN_BASE + 16'(acc);
      if ($urandom_range(0, 3) == 0) do_card(4'($urandom));  // ignored mid-session
      while (m_phase == 1) begin
        if ($urandom_range(0, 1) == 0) do_pin(good);
        else do_pin(good ^ 16'($urandom_range(1, 65535)));
      end
      if (m_phase == 2) begin
        ncmd = $urandom_range(1, 4);
        for (int c = 0; c < ncmd; c++) begin
          logic [9:0] amt;
          amt = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom);
          if ($urandom_range(0, 4) == 0) do_card(4'($urandom));  // ignored at menu
          do_cmd(2'($urandom_range(1, 3)), amt, 4'($urandom), 2'($urandom), 10'($urandom),
                 $urandom_range(0, 5), 1'b0);
        end
        do_cmd(2'd0, 10'($urandom), 4'($urandom), 2'd0, 10'd0, 0, 1'b0);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      do_pin(16'($urandom));  // ignored outside a session
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    card_in = 1'b0; card_acc = '0; pin_valid = 1'b0; pin_code = '0;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_amount = '0; cmd_dest = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Balance inquiry on account 5.
    do_card(4'd5);
    do_pin(16'h1005);
    do_cmd(2'd1, 10'd0, 4'd0, 2'd3, 10'd100, 4, 1'b0);
    check("balance_after_inquiry", balance_out, 10'd100);
    do_cmd(2'd0, 10'd0, 4'd0, 2'd0, 10'd0, 0, 1'b0);

    // Three wrong PINs lock account 2, then it is refused.
    do_card(4'd2);
    repeat (3) do_pin(16'h0000);
    do_card(4'd2);

    // Invalid card number.
    do_card(4'hF);
    check("session_active_bad_card", session_active, 0);

    // Transfer to self refused, then insufficient transfer.
    do_card(4'd3);
    do_pin(16'h1003);
    do_cmd(2'd3, 10'd200, 4'd3, 2'd0, 10'd0, 0, 1'b0);
    do_cmd(2'd3, 10'd200, 4'd4, 2'd2, 10'd0, 2, 1'b0);
    do_cmd(2'd0, 10'd0, 4'd0, 2'd0, 10'd0, 0, 1'b0);

    // Reset during an outstanding withdraw, then a fresh session on card 2.
    do_card(4'd1);
    do_pin(16'h1001);
    do_cmd(2'd2, 10'd50, 4'd0, 2'd3, 10'd0, 0, 1'b1);
    n = 0;
    while (!core_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("core_req_before_reset", core_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreq_reset");
    m_lock = '0; m_phase = 0; m_tries = 0; m_bal = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_card(4'd2);
    do_pin(16'h1002);
    do_cmd(2'd1, 10'd0, 4'd0, 2'd3, 10'd7, 1, 1'b0);
    do_cmd(2'd0, 10'd0, 4'd0, 2'd0, 10'd0, 0, 1'b0);

`ifdef ATM_TIMEOUT_EN
    // No PIN entered: inactivity timeout ends the session.
    do_card(4'd0);
    push_stat(3'd6, 1'b1);
    m_phase = 0;
    m_tries = 0;
    repeat (20) @(negedge clk);
    check("session_active_timeout", session_active, 0);
`endif

    for (int s = 0; s < 40; s++) random_session();

    repeat (5) @(negedge clk);
    check("status_queue_drained", stat_q.size(), 0);
    check("request_queue_drained", req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
